// File: rtl/reg_wb_arbiter_if.sv
// Register-file writeback bus: pipeline write, multicycle result handshake, issue/query, r3 write port.
// Latency: none, this is wiring only.
// Backpressure: b_ready gates multicycle results; a_stall asks the pipeline to hold its writeback.
// Ports: master = pipeline/decode/multicycle side, slave = arbiter side.
interface reg_wb_arbiter_if;
    logic        a_wr;
    logic [4:0]  a_addr;
    logic [31:0] a_din;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_din;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_busy;
    logic        q2_busy;
    logic        r3_wr;
    logic [4:0]  r3_addr;
    logic [31:0] r3_din;

    modport master (
        output a_wr, a_addr, a_din, b_valid, b_addr, b_din,
               iss_valid, iss_addr, q1_addr, q2_addr,
        input  a_stall, b_ready, q1_busy, q2_busy, r3_wr, r3_addr, r3_din
    );

    modport slave (
        input  a_wr, a_addr, a_din, b_valid, b_addr, b_din,
               iss_valid, iss_addr, q1_addr, q2_addr,
        output a_stall, b_ready, q1_busy, q2_busy, r3_wr, r3_addr, r3_din
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between pipeline writeback (A) and a FIFO of multicycle results (B).
// Latency: A write in t appears on r3 in t+1; B accepted in t appears on r3 no earlier than t+2.
// Backpressure: b_ready drops when the FIFO is full; a_stall rises after STARVE_MAX cycles of B losing to A.
// Ports: clk, rst (sync, active high); bus = slave side of reg_wb_arbiter_if.
module reg_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_dat  [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;
    // Bit 0 is never set, so r0 always reads as not busy.
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;

    logic          fifo_ne;
    logic          grant_a;
    logic          grant_b;
    logic          b_rdy;
    logic          push;
    logic [4:0]    head_addr;
    logic [31:0]   head_dat;

    always_comb begin
        fifo_ne   = (count != '0);
        grant_a   = bus.a_wr && (bus.a_addr != 5'd0);
        grant_b   = !grant_a && fifo_ne;
        // Registered count only: a pop in this cycle does not open a slot until the next one.
        b_rdy     = (count < (AW+1)'(DEPTH)) && !rst;
        // Results for r0 complete the handshake but are dropped.
        push      = bus.b_valid && b_rdy && (bus.b_addr != 5'd0);
        head_addr = fifo_addr[rd_ptr];
        head_dat  = fifo_dat[rd_ptr];
    end

    // Clear on commit first, then set on issue, so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (grant_b) begin
            busy_nxt[head_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign bus.b_ready = b_rdy;
    assign bus.a_stall = (starve_cnt == SW'(STARVE_MAX));
    assign bus.q1_busy = (bus.q1_addr != 5'd0) && busy[bus.q1_addr];
    assign bus.q2_busy = (bus.q2_addr != 5'd0) && busy[bus.q2_addr];

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.b_addr;
            fifo_dat[wr_ptr]  <= bus.b_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_b) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !grant_b) begin
                count <= count + 1'b1;
            end else if (!push && grant_b) begin
                count <= count - 1'b1;
            end
            // Counts cycles a waiting B head loses to A; saturates and holds if A ignores a_stall.
            if (grant_a && fifo_ne) begin
                if (starve_cnt != SW'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r3_wr   <= 1'b0;
            bus.r3_addr <= 5'd0;
            bus.r3_din  <= 32'd0;
        end else if (grant_a) begin
            bus.r3_wr   <= 1'b1;
            bus.r3_addr <= bus.a_addr;
            bus.r3_din  <= bus.a_din;
        end else if (grant_b) begin
            bus.r3_wr   <= 1'b1;
            bus.r3_addr <= head_addr;
            bus.r3_din  <= head_dat;
        end else begin
            bus.r3_wr   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: directed stimulus, expected commits queued with their cycle, checked by a monitor.
// Latency: commits are compared against the exact cycle they are due.
// Backpressure: b_ready and a_stall are checked directly at the cycles they must change.
module tb_reg_wb_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t expq[$];

    reg_wb_arbiter_if bus();

    reg_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_commit(input logic [4:0] a, input logic [31:0] d, input int due);
        exp_t e;
        e.addr = a;
        e.dat  = d;
        e.due  = due;
        expq.push_back(e);
    endtask

    task automatic b_push(input logic [4:0] a, input logic [31:0] d);
        bus.b_valid = 1'b1;
        bus.b_addr  = a;
        bus.b_din   = d;
    endtask

    // Monitor: every r3 write must match the next queued commit, including its cycle.
    always @(negedge clk) begin
        if (bus.r3_wr === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got addr %0d data %h at cycle %0d, none expected",
                         bus.r3_addr, bus.r3_din, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (bus.r3_addr !== e.addr || bus.r3_din !== e.dat || cyc != e.due) begin
                    errors++;
                    $display("FAIL commit: got addr %0d data %h cycle %0d expected addr %0d data %h cycle %0d",
                             bus.r3_addr, bus.r3_din, cyc, e.addr, e.dat, e.due);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.a_wr = 1'b0;  bus.a_addr = '0;  bus.a_din = '0;
        bus.b_valid = 1'b0;  bus.b_addr = '0;  bus.b_din = '0;
        bus.iss_valid = 1'b0;  bus.iss_addr = '0;
        bus.q1_addr = '0;  bus.q2_addr = '0;

        // Reset state
        step();
        chk("b_ready_in_reset", bus.b_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("b_ready_after_reset", bus.b_ready, 1'b1);
        chk("r3_wr_reset", bus.r3_wr, 1'b0);
        chk("r3_addr_reset", bus.r3_addr, 5'd0);
        chk("r3_din_reset", bus.r3_din, 32'd0);
        chk("a_stall_reset", bus.a_stall, 1'b0);

        // Single A write, then r3_wr drops and address/data hold
        step();
        bus.a_wr = 1'b1;  bus.a_addr = 5'd5;  bus.a_din = 32'hDEADBEEF;
        expect_commit(5'd5, 32'hDEADBEEF, cyc + 1);
        step();
        bus.a_wr = 1'b0;
        step();
        chk("a_r3_wr_drops", bus.r3_wr, 1'b0);
        chk("a_r3_addr_holds", bus.r3_addr, 5'd5);
        chk("a_r3_din_holds", bus.r3_din, 32'hDEADBEEF);

        // Issue to r9, then B result for r9
        step();
        bus.iss_valid = 1'b1;  bus.iss_addr = 5'd9;
        bus.q1_addr = 5'd9;  bus.q2_addr = 5'd9;
        #1;
        chk("q1_busy_same_cycle", bus.q1_busy, 1'b0);
        step();
        bus.iss_valid = 1'b0;
        chk("q1_busy_after_iss", bus.q1_busy, 1'b1);
        chk("q2_busy_after_iss", bus.q2_busy, 1'b1);
        chk("b_ready_idle", bus.b_ready, 1'b1);
        b_push(5'd9, 32'h1234);
        expect_commit(5'd9, 32'h1234, cyc + 2);
        step();
        bus.b_valid = 1'b0;
        chk("q1_busy_before_commit", bus.q1_busy, 1'b1);
        step();
        chk("r3_wr_b_commit", bus.r3_wr, 1'b1);
        chk("q1_busy_at_commit", bus.q1_busy, 1'b0);

        // Starvation: A held six cycles while B waits
        step();
        for (int i = 0; i < 6; i++) begin
            bus.a_wr = 1'b1;  bus.a_addr = 5'd7;  bus.a_din = 32'h700 + i;
            if (i == 0) b_push(5'd3, 32'hA);
            else bus.b_valid = 1'b0;
            expect_commit(5'd7, 32'h700 + i, cyc + 1);
            chk($sformatf("a_stall_starve_%0d", i), bus.a_stall, (i == 5) ? 1'b1 : 1'b0);
            step();
        end
        bus.a_wr = 1'b0;
        chk("a_stall_held", bus.a_stall, 1'b1);
        expect_commit(5'd3, 32'hA, cyc + 1);
        step();
        chk("a_stall_falls", bus.a_stall, 1'b0);

        // Fill the FIFO behind A, third result must be refused
        step();
        for (int k = 0; k < 4; k++) begin
            bus.a_wr = 1'b1;  bus.a_addr = 5'd7;  bus.a_din = 32'h800 + k;
            expect_commit(5'd7, 32'h800 + k, cyc + 1);
            if (k == 0) b_push(5'd1, 32'h11);
            else if (k == 1) b_push(5'd2, 32'h22);
            else begin
                b_push(5'd8, 32'h88);
                chk($sformatf("b_ready_full_%0d", k), bus.b_ready, 1'b0);
            end
            step();
        end
        bus.a_wr = 1'b0;
        bus.b_valid = 1'b0;
        chk("b_ready_during_pop", bus.b_ready, 1'b0);
        expect_commit(5'd1, 32'h11, cyc + 1);
        expect_commit(5'd2, 32'h22, cyc + 2);
        step();
        chk("b_ready_after_pop", bus.b_ready, 1'b1);
        step();
        step();

        // Register zero handling
        b_push(5'd4, 32'h44);
        step();
        bus.b_valid = 1'b0;
        bus.a_wr = 1'b1;  bus.a_addr = 5'd0;  bus.a_din = 32'hBAD;
        expect_commit(5'd4, 32'h44, cyc + 1);
        step();
        bus.a_wr = 1'b0;
        b_push(5'd0, 32'h55);
        bus.iss_valid = 1'b1;  bus.iss_addr = 5'd0;
        bus.q1_addr = 5'd0;  bus.q2_addr = 5'd0;
        step();
        bus.b_valid = 1'b0;
        bus.iss_valid = 1'b0;
        chk("q1_busy_r0", bus.q1_busy, 1'b0);
        chk("q2_busy_r0", bus.q2_busy, 1'b0);
        chk("b_ready_after_r0_push", bus.b_ready, 1'b1);
        step();
        step();

        // Reset with two FIFO entries and r6 busy
        bus.iss_valid = 1'b1;  bus.iss_addr = 5'd6;
        bus.a_wr = 1'b1;  bus.a_addr = 5'd7;  bus.a_din = 32'h900;
        b_push(5'd6, 32'h66);
        expect_commit(5'd7, 32'h900, cyc + 1);
        step();
        bus.iss_valid = 1'b0;
        bus.a_din = 32'h901;
        b_push(5'd10, 32'hAA);
        expect_commit(5'd7, 32'h901, cyc + 1);
        bus.q1_addr = 5'd6;
        #1;
        chk("q1_busy_r6_before_reset", bus.q1_busy, 1'b1);
        step();
        bus.a_wr = 1'b0;
        bus.b_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("b_ready_mid_reset", bus.b_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("r3_wr_after_reset", bus.r3_wr, 1'b0);
        chk("q1_busy_r6_after_reset", bus.q1_busy, 1'b0);
        chk("b_ready_after_mid_reset", bus.b_ready, 1'b1);
        for (int j = 0; j < 4; j++) step();

        chk("pending_commits", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (r3_wr/r3_addr/r3_din) between two writeback sources.
- Source A is the main pipeline writeback: fixed-priority, no backpressure.
- Source B is the multicycle unit writeback (mult/div, slow loads): valid/ready handshake into a small FIFO.
- A per-register scoreboard tracks destinations issued to B but not yet committed, so decode can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 2, B-side FIFO entries (power of 2, ≥2).
- STARVE_MAX, 4, consecutive cycles B head may lose to A before a_stall asserts (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_wr  in  1  pipeline writeback enable
- a_addr  in  5  pipeline writeback register
- a_din  in  32  pipeline writeback data
- a_stall  out  1  request: pipeline must hold a_wr low next cycle(s)
- b_valid  in  1  multicycle result valid
- b_ready  out  1  FIFO can accept
- b_addr  in  5  multicycle result register
- b_din  in  32  multicycle result data
- iss_valid  in  1  multicycle op dispatched this cycle
- iss_addr  in  5  its destination register
- q1_addr  in  5  decode source 1 query
- q2_addr  in  5  decode source 2 query
- q1_busy  out  1  q1_addr has pending B write
- q2_busy  out  1  q2_addr has pending B write
- r3_wr  out  1  to register file write enable
- r3_addr  out  5  to register file write address
- r3_din  out  32  to register file write data

Behaviour:
- Reset (rst high at posedge):
  - r3_wr=0, r3_addr=0, r3_din=0; FIFO empty; all busy bits 0; starve counter 0.
  - b_ready forced 0 while rst high; handshakes and iss_valid ignored during reset.
  - Reset mid-operation discards FIFO contents and scoreboard.
- Grant, evaluated each cycle:
  - a_wr && a_addr!=0 → grant A.
  - Else FIFO non-empty → grant B head, pop.
  - Else no grant.
- Outputs r3_* are registered: the granted addr/data appear the cycle after grant, with r3_wr=1. With no grant, r3_wr=0 and r3_addr/r3_din hold their previous values.
- Latency:
  - A: a_wr in cycle t → r3_wr in t+1.
  - B: accept in t → earliest r3_wr in t+2.
- B handshake:
  - Transfer occurs when b_valid && b_ready at posedge.
  - b_ready = (count<DEPTH) && !rst, from registered count only; a same-cycle pop does not raise it.
  - A transfer with b_addr==0 is accepted and discarded: not enqueued, no scoreboard effect.
  - FIFO order is strict in-order.
  - Simultaneous push and pop are both performed; count is unchanged.
- Scoreboard: busy[31:1].
  - iss_valid && iss_addr!=0 sets busy[iss_addr].
  - A B commit (grant of B head) clears busy[head addr].
  - Set and clear of the same register in the same cycle: set wins.
  - A writes never change busy bits.
  - Only one outstanding B op per register is supported. Decode must not issue to a busy destination; the busy output provides that check.
- Queries (combinational from registered busy bits):
  - qN_busy = busy[qN_addr]; addr 0 → 0.
  - Same-cycle iss/commit is not reflected until the next cycle.
- Starvation:
  - starve_cnt increments (saturating at STARVE_MAX) each cycle the FIFO is non-empty and A is granted.
  - It clears when B is granted or the FIFO is empty.
  - a_stall = (starve_cnt==STARVE_MAX).
  - If a_wr stays high while a_stall is asserted (protocol violation), A still wins; no data is lost and the counter holds.
- a_wr with a_addr==0: treated as no request; B may be granted that cycle.

Test Plan:
- Reset, then a_wr=1, a_addr=5, a_din=0xDEADBEEF for one cycle → next cycle r3_wr=1, r3_addr=5, r3_din=0xDEADBEEF; the following cycle r3_wr=0.
- iss_valid, iss_addr=9 → q1_addr=9 gives q1_busy=1 next cycle.
  - Then b push (9, 0x1234) with A idle → r3_wr at t+2 with addr 9, data 0x1234.
  - busy[9] clears at the commit edge; q1_busy=0 in the cycle r3_wr is high.
- Conflict: b push (3, 0xA), FIFO then holds 1 entry; a_wr held high (addr 7) for 6 cycles, STARVE_MAX=4.
  - B not granted; a_stall rises after 4 losing cycles.
  - Drop a_wr → B commits next cycle, a_stall falls.
- Fill: with a_wr held high, push (1,0x11), (2,0x22) → b_ready=0 with count=2, a third b_valid not accepted.
  - Release A → commits 1 then 2 on consecutive cycles.
  - b_ready returns high the cycle after the first pop.
- Zero register: a_wr with addr 0 while FIFO holds (4,0x44) → B granted that cycle.
  - b push with addr 0 → no r3_wr.
  - iss_addr=0 → q busy stays 0.
- Assert rst with FIFO holding 2 entries and busy[6]=1 → next cycle r3_wr=0, q busy(6)=0, no pending commits, b_ready=1 after rst drops.
